serial_rx_fifo: RTL and testbench

Parametrised UART receiver with a show-ahead receive FIFO, replacing the fixed 8N1 single-byte serial_in.
- Used both in the system (console input) and in simulation tops, where it monitors the CPU TXD line and prints received characters.
- Adds configurable data width, parity, oversampling rate and buffering depth, plus sticky error reporting.

---
 rtl/serial_rx_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/serial_rx_fifo.sv | 173 +++++++++++++++++
 tb/tb_serial_rx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// ----------------------------------------------------------------------------
// serial_rx_pkg : shared constants for the serial receive path
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : single-clock show-ahead FIFO with occupancy count
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic [AW:0]      count_o
);

  localparam int         DEPTH   = 2 ** AW;
  localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (cnt_q == '0);
  assign w_full  = (cnt_q == c_DEPTH);
  assign w_pop   = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push  = push_i & (~w_full | w_pop);

  assign push_ok_o = w_push;
  assign count_o   = cnt_q;
  assign data_o    = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + AW'(1);
      if (w_pop)  rd_q <= rd_q + AW'(1);
      if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// serial_rx_fifo : parametrised UART receiver feeding a show-ahead FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_rx_fifo
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic                 m_clock,
  input  logic                 p_reset,
  input  logic                 rxd,
  input  logic                 port_read,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rxready,
  output logic                 done,
  output logic [FIFO_AW:0]     count,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    c_LAST = 4'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("serial_rx_fifo: unsupported parameter combination");
    end
  endgenerate

  logic                 sync1_q;
  logic                 rxs_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_q;
  logic                 ferr_q, perr_q, ovr_q;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_push_ok;
  logic                 w_ferr;
  logic                 w_perr;
  logic                 w_empty;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  assign w_tick = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    w_push  = 1'b0;
    w_ferr  = 1'b0;
    w_perr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = c_HALF;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (!w_tick) begin
          baud_d = baud_q - 1'b1;
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          baud_d  = c_FULL;
        end
      end
      S_DATA: begin
        if (!w_tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          baud_d  = c_FULL;
          bit_d   = bit_q + 4'd1;
          if (bit_q == c_LAST) state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (!w_tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          w_perr  = rxs_q != ((^shift_q) ^ (PARITY == PAR_ODD));
          state_d = S_STOP;
          baud_d  = c_FULL;
        end
      end
      S_STOP: begin
        // Only the first stop bit is checked; an idle-high line covers the second.
        if (!w_tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          w_push  = rxs_q;
          w_ferr  = ~rxs_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= w_push_ok;
      ferr_q  <= w_ferr | (ferr_q & ~err_clr);
      perr_q  <= w_perr | (perr_q & ~err_clr);
      ovr_q   <= (w_push & ~w_push_ok) | (ovr_q & ~err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i     (m_clock),
    .rst_ni    (p_reset),
    .push_i    (w_push),
    .data_i    (shift_q),
    .pop_i     (port_read),
    .data_o    (data),
    .empty_o   (w_empty),
    .push_ok_o (w_push_ok),
    .count_o   (count)
  );

  assign rxready    = ~w_empty;
  assign done       = done_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_serial_rx_fifo : checks two receiver configurations against a frame-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_rx_fifo;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       rxd   [2];
  logic       rd    [2];
  logic       clr   [2];
  logic [7:0] dat   [2];
  logic       rdy   [2];
  logic       dn    [2];
  logic       fe    [2];
  logic       pe    [2];
  logic       ov    [2];
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;

  serial_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u_dut_a (
    .m_clock(clk), .p_reset(rst_n[0]), .rxd(rxd[0]), .port_read(rd[0]), .err_clr(clr[0]),
    .data(dat[0]), .rxready(rdy[0]), .done(dn[0]), .count(cnt_a),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

  serial_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(1), .STOP_BITS(1), .FIFO_AW(4)) u_dut_b (
    .m_clock(clk), .p_reset(rst_n[1]), .rxd(rxd[1]), .port_read(rd[1]), .err_clr(clr[1]),
    .data(dat[1]), .rxready(rdy[1]), .done(dn[1]), .count(cnt_b),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

  // Frame-level model: events land on the edge the receiver must act on them.
  typedef struct {
    int         inst;
    int         at;
    int         kind;   // 0 push, 1 frame error, 2 parity error
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  ev_t        keep[$];
  logic [7:0] mmem [2][16];
  int         mhead [2];
  int         msize [2];
  logic       mdone [2];
  logic       mfe   [2];
  logic       mpe   [2];
  logic       mov   [2];
  logic       preq  [2];
  logic       pfe   [2];
  logic       ppe   [2];
  logic [7:0] pdat  [2];
  logic       m_pop, m_pushok;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         done_seen [2];
  bit         rand_on = 1'b0;

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 16;
  endfunction

  function automatic int has_par(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; msize[i] = 0; mdone[i] = 0; mfe[i] = 0; mpe[i] = 0; mov[i] = 0;
      done_seen[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        preq[i] = 0; pfe[i] = 0; ppe[i] = 0; pdat[i] = '0;
      end
      keep.delete();
      foreach (evq[k]) begin
        if (!rst_n[evq[k].inst]) begin
          // aborted by reset
        end else if (evq[k].at == cyc) begin
          case (evq[k].kind)
            0: begin preq[evq[k].inst] = 1'b1; pdat[evq[k].inst] = evq[k].d; end
            1: pfe[evq[k].inst] = 1'b1;
            default: ppe[evq[k].inst] = 1'b1;
          endcase
        end else begin
          keep.push_back(evq[k]);
        end
      end
      evq = keep;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          mhead[i] = 0; msize[i] = 0; mdone[i] = 0; mfe[i] = 0; mpe[i] = 0; mov[i] = 0;
        end else begin
          m_pop    = rd[i] && (msize[i] > 0);
          m_pushok = preq[i] && ((msize[i] < dep(i)) || m_pop);
          if (m_pop) begin
            mhead[i] = (mhead[i] + 1) % dep(i);
            msize[i]--;
          end
          if (m_pushok) begin
            mmem[i][(mhead[i] + msize[i]) % dep(i)] = pdat[i];
            msize[i]++;
          end
          mdone[i] = m_pushok;
          mfe[i]   = pfe[i] | (mfe[i] & ~clr[i]);
          mpe[i]   = ppe[i] | (mpe[i] & ~clr[i]);
          mov[i]   = (preq[i] & ~m_pushok) | (mov[i] & ~clr[i]);
        end
      end
    end
  end

  initial begin
    logic [9:0] act, exp;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        act = {rdy[i], (i == 0) ? {2'b00, cnt_a} : cnt_b, dn[i], fe[i], pe[i], ov[i]};
        if (!rst_n[i]) exp = '0;
        else exp = {msize[i] > 0, 5'(msize[i]), mdone[i], mfe[i], mpe[i], mov[i]};
        chk($sformatf("status%0d {rdy,cnt,done,fe,pe,ov}", i), {22'd0, act}, {22'd0, exp});
        if (rst_n[i] && msize[i] > 0) chk($sformatf("head%0d", i), {24'd0, dat[i]}, {24'd0, mmem[i][mhead[i]]});
        if (dn[i]) done_seen[i]++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) begin
        rd[1]  = ($urandom % 3) == 0;
        clr[1] = ($urandom % 16) == 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 300000", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par, input bit stop_val);
    int   e0   = cyc + 1;
    int   p    = has_par(i);
    int   base = e0 + 2 + CPB / 2;
    logic pb   = (^d) ^ bad_par;
    ev_t  e;
    if (p != 0 && bad_par) begin
      e = '{i, base + CPB * (DB + 1), 2, 8'h00};
      evq.push_back(e);
    end
    e = '{i, base + CPB * (DB + p + 1), stop_val ? 0 : 1, d};
    evq.push_back(e);
    rxd[i] = 1'b0;
    step(CPB);
    for (int b = 0; b < DB; b++) begin
      rxd[i] = d[b];
      step(CPB);
    end
    if (p != 0) begin
      rxd[i] = pb;
      step(CPB);
    end
    rxd[i] = stop_val;
    step(CPB);
    rxd[i] = 1'b1;
    step(24);
  endtask

  task automatic pop_chk(input int i, input logic [7:0] exp);
    chk("pop_order", {24'd0, dat[i]}, {24'd0, exp});
    rd[i] = 1'b1;
    step(1);
    rd[i] = 1'b0;
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1;
    step(1);
    clr[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         n0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; rxd[i] = 1'b1; rd[i] = 1'b0; clr[i] = 1'b0;
    end
    step(2);
    chk("reset_rxready", {31'd0, rdy[0]}, 32'd0);
    chk("reset_count", {29'd0, cnt_a}, 32'd0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step(4);

    // 8N1 frame, then a single pop
    send_frame(0, 8'h41, 1'b0, 1'b1);
    chk("t1_done_pulses", done_seen[0], 1);
    chk("t1_data", {24'd0, dat[0]}, 32'h41);
    chk("t1_count", {29'd0, cnt_a}, 32'd1);
    rd[0] = 1'b1;
    step(1);
    rd[0] = 1'b0;
    chk("t1_empty_after_pop", {31'd0, rdy[0]}, 32'd0);

    // short glitch is a false start
    rxd[0] = 1'b0;
    step(5);
    rxd[0] = 1'b1;
    step(30);
    chk("t2_count", {29'd0, cnt_a}, 32'd0);
    chk("t2_no_done", done_seen[0], 1);

    // bad stop bit
    send_frame(0, 8'h55, 1'b0, 1'b0);
    chk("t4_frame_err", {31'd0, fe[0]}, 32'd1);
    chk("t4_count", {29'd0, cnt_a}, 32'd0);
    chk("t4_no_done", done_seen[0], 1);
    pulse_clr(0);
    chk("t4_cleared", {31'd0, fe[0]}, 32'd0);

    // overflow of a 4-deep FIFO
    for (int k = 0; k < 5; k++) send_frame(0, 8'(8'h10 + k), 1'b0, 1'b1);
    chk("t5_count", {29'd0, cnt_a}, 32'd4);
    chk("t5_overrun", {31'd0, ov[0]}, 32'd1);
    for (int k = 0; k < 4; k++) pop_chk(0, 8'(8'h10 + k));
    chk("t5_drained", {31'd0, rdy[0]}, 32'd0);
    pulse_clr(0);

    // pop coinciding with a push into a full FIFO
    for (int k = 0; k < 4; k++) send_frame(0, 8'(8'h20 + k), 1'b0, 1'b1);
    n0 = 2 + CPB / 2 + CPB * (DB + 1);
    fork
      send_frame(0, 8'h24, 1'b0, 1'b1);
      begin
        step(n0);
        rd[0] = 1'b1;
        step(1);
        rd[0] = 1'b0;
      end
    join
    chk("t6_count", {29'd0, cnt_a}, 32'd4);
    chk("t6_no_overrun", {31'd0, ov[0]}, 32'd0);
    for (int k = 1; k < 5; k++) pop_chk(0, 8'(8'h20 + k));

    // reset in the middle of a frame
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    rxd[0] = 1'b0;
    step(60);
    rst_n[0] = 1'b0;
    #2;
    chk("rst_rxready", {31'd0, rdy[0]}, 32'd0);
    chk("rst_count", {29'd0, cnt_a}, 32'd0);
    chk("rst_data", {24'd0, dat[0]}, 32'd0);
    rxd[0] = 1'b1;
    step(3);
    rst_n[0] = 1'b1;
    step(5);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    chk("rst_next_frame", {24'd0, dat[0]}, 32'h3C);
    pop_chk(0, 8'h3C);

    // even parity, wrong parity bit
    send_frame(1, 8'h03, 1'b1, 1'b1);
    chk("t3_parity_err", {31'd0, pe[1]}, 32'd1);
    chk("t3_data", {24'd0, dat[1]}, 32'h03);
    chk("t3_count", {27'd0, cnt_b}, 32'd1);
    pulse_clr(1);
    chk("t3_cleared", {31'd0, pe[1]}, 32'd0);
    pop_chk(1, 8'h03);

    // randomized traffic with random pops and flag clears
    rand_on = 1'b1;
    for (int k = 0; k < 14; k++) begin
      d = 8'($urandom);
      send_frame(1, d, ($urandom % 4) == 0, ($urandom % 8) != 0);
    end
    rand_on = 1'b0;
    step(1);
    rd[1]  = 1'b0;
    clr[1] = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
